// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program-launch sequencer.
package prog_seq_pkg;

    localparam int PROG_W          = 2;
    localparam int INIT_CYCLES_DEF = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INIT_HI = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/prog_sequencer.sv
// Launches NUM_PROGS programs on the core via init pulses and waits for Halt after each one.
// Optional per-program watchdog is built when PROG_TIMEOUT_EN is defined.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int NUM_PROGS      = 3,
    parameter int INIT_CYCLES    = INIT_CYCLES_DEF,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              Halt,
    output logic              init,
    output logic [PROG_W-1:0] ProgState,
    output logic              busy,
    output logic              prog_done,
    output logic [CNT_W-1:0]  CycleCount,
    output logic              seq_done,
    output logic              timed_out,
    output seq_state_t        dbg_state
);

    localparam int                INIT_W      = $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LOAD   = INIT_W'(INIT_CYCLES - 1);
    localparam logic [PROG_W-1:0] LAST_PROG   = PROG_W'(NUM_PROGS);
    localparam logic [CNT_W-1:0]  TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    seq_state_t        state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_q, init_d;
    logic [PROG_W-1:0] prog_q, prog_d;
    logic              busy_q, busy_d;
    logic              prog_done_q, prog_done_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              seq_done_q, seq_done_d;
    logic              timed_out_q, timed_out_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [CNT_W-1:0]  run_cnt;
    logic              hit_timeout;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_run_cnt (
        .clk   (CLK),
        .rst_n (Reset_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (run_cnt)
    );

`ifdef PROG_TIMEOUT_EN
    assign hit_timeout = !Halt && (run_cnt == TIMEOUT_VAL);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_VAL;
    assign hit_timeout    = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        init_d        = 1'b0;
        prog_d        = prog_q;
        prog_done_d   = 1'b0;
        cycle_count_d = cycle_count_q;
        timed_out_d   = timed_out_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = INIT_HI;
                    init_cnt_d = INIT_LOAD;
                end
            end
            // First INIT_HI cycle only raises init; the count runs while init is already high.
            INIT_HI: begin
                if (!init_q) begin
                    init_d = 1'b1;
                end else if (init_cnt_q == '0) begin
                    state_d = RUN;
                    prog_d  = prog_q + PROG_W'(1);
                    cnt_clr = 1'b1;
                end else begin
                    init_d     = 1'b1;
                    init_cnt_d = init_cnt_q - INIT_W'(1);
                end
            end
            RUN: begin
                cnt_en = !Halt;
                if (Halt || hit_timeout) begin
                    cycle_count_d = run_cnt;
                    prog_done_d   = 1'b1;
                    if (hit_timeout) begin
                        timed_out_d = 1'b1;
                    end
                    if (prog_q == LAST_PROG) begin
                        state_d = DONE;
                    end else begin
                        state_d    = INIT_HI;
                        init_cnt_d = INIT_LOAD;
                    end
                end
            end
            DONE: begin
                if (start) begin
                    prog_d      = '0;
                    timed_out_d = 1'b0;
                    state_d     = INIT_HI;
                    init_cnt_d  = INIT_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d == INIT_HI) || (state_d == RUN);
        seq_done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            init_cnt_q    <= '0;
            init_q        <= 1'b0;
            prog_q        <= '0;
            busy_q        <= 1'b0;
            prog_done_q   <= 1'b0;
            cycle_count_q <= '0;
            seq_done_q    <= 1'b0;
            timed_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            init_q        <= init_d;
            prog_q        <= prog_d;
            busy_q        <= busy_d;
            prog_done_q   <= prog_done_d;
            cycle_count_q <= cycle_count_d;
            seq_done_q    <= seq_done_d;
            timed_out_q   <= timed_out_d;
        end
    end

    assign init       = init_q;
    assign ProgState  = prog_q;
    assign busy       = busy_q;
    assign prog_done  = prog_done_q;
    assign CycleCount = cycle_count_q;
    assign seq_done   = seq_done_q;
    assign timed_out  = timed_out_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed and randomized bench for prog_sequencer; expected timing is derived from the launch/run timeline.
module tb_prog_sequencer;
    import prog_seq_pkg::*;

    localparam int NUM_PROGS      = 3;
    localparam int INIT_CYCLES    = 4;
    localparam int CNT_W          = 32;
    localparam int TIMEOUT_CYCLES = 50;

    logic             CLK = 1'b0;
    logic             Reset_n;
    logic             start;
    logic             Halt;
    logic             init;
    logic [1:0]       ProgState;
    logic             busy;
    logic             prog_done;
    logic [CNT_W-1:0] CycleCount;
    logic             seq_done;
    logic             timed_out;
    seq_state_t       dbg_state;

    int vec_cnt     = 0;
    int miscompares = 0;
    logic [CNT_W-1:0] exp_q[$];

    always #5 CLK = ~CLK;

    prog_sequencer #(
        .NUM_PROGS      (NUM_PROGS),
        .INIT_CYCLES    (INIT_CYCLES),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .CLK        (CLK),
        .Reset_n    (Reset_n),
        .start      (start),
        .Halt       (Halt),
        .init       (init),
        .ProgState  (ProgState),
        .busy       (busy),
        .prog_done  (prog_done),
        .CycleCount (CycleCount),
        .seq_done   (seq_done),
        .timed_out  (timed_out),
        .dbg_state  (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_init"}, init, 0);
        check({tag, "_prog_state"}, ProgState, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_prog_done"}, prog_done, 0);
        check({tag, "_cycle_count"}, CycleCount, 0);
        check({tag, "_seq_done"}, seq_done, 0);
        check({tag, "_timed_out"}, timed_out, 0);
        check({tag, "_state"}, dbg_state, IDLE);
    endtask

    // start sampled at the next edge; outputs after it: init still low, busy up, fresh sequence.
    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
        check("launch_init", init, 0);
        check("launch_busy", busy, 1);
        check("launch_prog_state", ProgState, 0);
        check("launch_seq_done", seq_done, 0);
        check("launch_timed_out", timed_out, 0);
    endtask

    // One program: init high INIT_CYCLES clocks, then r Halt-low RUN cycles, then completion.
    task automatic run_prog(input int idx, input int r, input bit halt_always,
                            input int start_poke, input bit no_halt, input bit exp_to);
        bit last;
        last = (idx == NUM_PROGS);
        exp_q.push_back(CNT_W'(r));
        for (int j = 1; j <= INIT_CYCLES; j++) begin
            step();
            check("init_high", init, 1);
            check("init_prog_state", ProgState, idx - 1);
            check("init_busy", busy, 1);
            check("init_prog_done", prog_done, 0);
        end
        step();
        check("init_fall", init, 0);
        check("prog_state_inc", ProgState, idx);
        check("run_busy", busy, 1);
        for (int j = 0; j < r; j++) begin
            if (!halt_always) Halt = 1'b0;
            start = (j == start_poke);
            step();
            check("run_init", init, 0);
            check("run_prog_done", prog_done, 0);
            check("run_busy", busy, 1);
            check("run_prog_state", ProgState, idx);
        end
        start = 1'b0;
        Halt  = no_halt ? 1'b0 : 1'b1;
        step();
        check("end_prog_done", prog_done, 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 1, 0);
        end else begin
            check("cycle_count", CycleCount, exp_q.pop_front());
        end
        check("end_prog_state", ProgState, idx);
        check("end_init", init, 0);
        check("end_seq_done", seq_done, last);
        check("end_busy", busy, !last);
        check("end_timed_out", timed_out, exp_to);
        if (!halt_always) Halt = 1'b0;
    endtask

    task automatic hold_done(input bit exp_to);
        for (int j = 0; j < 2; j++) begin
            step();
            check("done_seq_done", seq_done, 1);
            check("done_busy", busy, 0);
            check("done_prog_done", prog_done, 0);
            check("done_init", init, 0);
            check("done_prog_state", ProgState, NUM_PROGS);
            check("done_timed_out", timed_out, exp_to);
            check("done_state", dbg_state, DONE);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        start   = 1'b0;
        Halt    = 1'b0;
        step();
        step();
        check_reset("reset");
        Reset_n = 1'b1;
        step();
        check_reset("idle");

        // Halt raised 10 cycles after init falls, then two random programs
        launch();
        run_prog(1, 10, 0, -1, 0, 0);
        run_prog(2, $urandom_range(0, 12), 0, -1, 0, 0);
        run_prog(3, $urandom_range(0, 12), 0, -1, 0, 0);
        hold_done(0);

        // Run lengths 5, 7, 9 restarted from DONE
        launch();
        run_prog(1, 5, 0, -1, 0, 0);
        run_prog(2, 7, 0, -1, 0, 0);
        run_prog(3, 9, 0, -1, 0, 0);
        hold_done(0);

        // Halt held high the whole sequence, including INIT_HI
        Halt = 1'b1;
        launch();
        run_prog(1, 0, 1, -1, 0, 0);
        run_prog(2, 0, 1, -1, 0, 0);
        run_prog(3, 0, 1, -1, 0, 0);
        Halt = 1'b0;
        hold_done(0);

        // start pulses inside RUN must be ignored
        launch();
        run_prog(1, 6, 0, 3, 0, 0);
        run_prog(2, 4, 0, 0, 0, 0);
        run_prog(3, 8, 0, 7, 0, 0);
        hold_done(0);
        launch();
        run_prog(1, 2, 0, -1, 0, 0);
        run_prog(2, 3, 0, -1, 0, 0);
        run_prog(3, 1, 0, -1, 0, 0);
        hold_done(0);

        // Reset during INIT_HI of program 2
        launch();
        run_prog(1, $urandom_range(1, 12), 0, -1, 0, 0);
        step();
        check("rst_pre_init", init, 1);
        step();
        Reset_n = 1'b0;
        step();
        check_reset("mid_reset");
        Reset_n = 1'b1;
        step();
        check_reset("post_reset_idle");

        // Randomized sequences from IDLE
        for (int s = 0; s < 3; s++) begin
            launch();
            for (int p = 1; p <= NUM_PROGS; p++) begin
                run_prog(p, $urandom_range(0, 15), 0, -1, 0, 0);
            end
            hold_done(0);
        end

`ifdef PROG_TIMEOUT_EN
        // Watchdog: Halt never arrives, each program ends after TIMEOUT_CYCLES
        launch();
        run_prog(1, TIMEOUT_CYCLES, 0, -1, 1, 1);
        run_prog(2, TIMEOUT_CYCLES, 0, -1, 1, 1);
        run_prog(3, TIMEOUT_CYCLES, 0, -1, 1, 1);
        hold_done(1);
        launch();
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
